// File: rtl/aes256_sbox_sched.sv
// Arbitrates one shared 4-lane S-box slice between the round datapath (4 word passes)
// and key expansion (one SubWord pass). Optional grant counters: AES_SBOX_SCHED_STATS_EN.
module aes256_sbox_sched #(
  parameter int KS_PRIORITY = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         dp_req_i,
  input  logic         dp_mode_i,
  input  logic [127:0] dp_state_i,
  output logic         dp_ack_o,
  output logic         dp_done_o,
  output logic [127:0] dp_state_o,
  input  logic         ks_req_i,
  input  logic [31:0]  ks_word_i,
  output logic         ks_ack_o,
  output logic         ks_done_o,
  output logic [31:0]  ks_word_o,
  output logic [31:0]  sb_word_o,
  output logic         sb_mode_o,
  input  logic [31:0]  sb_word_i,
`ifdef AES_SBOX_SCHED_STATS_EN
  output logic [15:0]  dp_grant_cnt_o,
  output logic [15:0]  ks_grant_cnt_o,
`endif
  output logic         busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_DP_RUN, ST_KS_RUN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              last_ks_q, last_ks_d;
  logic              dp_done_q, dp_done_d;
  logic              ks_done_q, ks_done_d;
  logic [3:0][31:0]  dp_state_q, dp_state_d;
  logic [31:0]       ks_word_q, ks_word_d;
  logic [3:0][31:0]  dp_in_q, dp_in_d;
  logic              dp_mode_q, dp_mode_d;
  logic [31:0]       ks_in_q, ks_in_d;
  logic              grant_dp, grant_ks;
  logic [31:0]       sb_word;
  logic              sb_mode;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_ks_d  = last_ks_q;
    dp_done_d  = 1'b0;
    ks_done_d  = 1'b0;
    dp_state_d = dp_state_q;
    ks_word_d  = ks_word_q;
    dp_in_d    = dp_in_q;
    dp_mode_d  = dp_mode_q;
    ks_in_d    = ks_in_q;
    grant_dp   = 1'b0;
    grant_ks   = 1'b0;
    sb_word    = '0;
    sb_mode    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ack is decided in the IDLE cycle itself so a done cycle can also accept.
        if (dp_req_i && ks_req_i) begin
          if (KS_PRIORITY != 0) grant_ks = 1'b1;
          else if (last_ks_q)   grant_dp = 1'b1;
          else                  grant_ks = 1'b1;
        end else if (dp_req_i) begin
          grant_dp = 1'b1;
        end else if (ks_req_i) begin
          grant_ks = 1'b1;
        end
        if (grant_dp) begin
          state_d   = ST_DP_RUN;
          idx_d     = 2'd0;
          last_ks_d = 1'b0;
          dp_in_d   = dp_state_i;
          dp_mode_d = dp_mode_i;
        end
        if (grant_ks) begin
          state_d   = ST_KS_RUN;
          last_ks_d = 1'b1;
          ks_in_d   = ks_word_i;
        end
      end
      ST_DP_RUN: begin
        // Word k sits in the most-significant-first packed slot 3-k.
        sb_word                      = dp_in_q[2'd3 - idx_q];
        sb_mode                      = dp_mode_q;
        dp_state_d[2'd3 - idx_q]     = sb_word_i;
        idx_d                        = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d   = ST_IDLE;
          dp_done_d = 1'b1;
        end
      end
      ST_KS_RUN: begin
        sb_word   = ks_in_q;
        ks_word_d = sb_word_i;
        ks_done_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      last_ks_q  <= 1'b1;
      dp_done_q  <= 1'b0;
      ks_done_q  <= 1'b0;
      dp_state_q <= '0;
      ks_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_ks_q  <= last_ks_d;
      dp_done_q  <= dp_done_d;
      ks_done_q  <= ks_done_d;
      dp_state_q <= dp_state_d;
      ks_word_q  <= ks_word_d;
    end
  end

  // Captured operands are only read in the RUN states, so they need no reset.
  always_ff @(posedge clk_i) begin
    dp_in_q   <= dp_in_d;
    dp_mode_q <= dp_mode_d;
    ks_in_q   <= ks_in_d;
  end

`ifdef AES_SBOX_SCHED_STATS_EN
  logic [15:0] dp_cnt_q, dp_cnt_d;
  logic [15:0] ks_cnt_q, ks_cnt_d;

  always_comb begin
    dp_cnt_d = dp_cnt_q;
    ks_cnt_d = ks_cnt_q;
    if (grant_dp && (dp_cnt_q != 16'hFFFF)) dp_cnt_d = dp_cnt_q + 16'd1;
    if (grant_ks && (ks_cnt_q != 16'hFFFF)) ks_cnt_d = ks_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dp_cnt_q <= '0;
      ks_cnt_q <= '0;
    end else begin
      dp_cnt_q <= dp_cnt_d;
      ks_cnt_q <= ks_cnt_d;
    end
  end

  assign dp_grant_cnt_o = dp_cnt_q;
  assign ks_grant_cnt_o = ks_cnt_q;
`endif

  assign dp_ack_o   = grant_dp;
  assign ks_ack_o   = grant_ks;
  assign dp_done_o  = dp_done_q;
  assign ks_done_o  = ks_done_q;
  assign dp_state_o = dp_state_q;
  assign ks_word_o  = ks_word_q;
  assign sb_word_o  = sb_word;
  assign sb_mode_o  = sb_mode;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes256_sbox_sched.sv
// Bench for aes256_sbox_sched: AES S-box tables derived from GF(2^8) arithmetic act as
// the shared slice and as the reference; a second instance exercises KS_PRIORITY=1.
module tb_aes256_sbox_sched;
  localparam int KS_PRIO = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         dp_req, dp_mode, ks_req;
  logic [127:0] dp_state_in;
  logic [31:0]  ks_word;
  logic         dp_ack, dp_done, ks_ack, ks_done, sb_mode_o, busy;
  logic [127:0] dp_state_o;
  logic [31:0]  ks_word_o, sb_word_o, sb_word_i;
  logic         k1_dp_ack, k1_dp_done, k1_ks_ack, k1_ks_done, k1_sb_mode_o, k1_busy;
  logic [127:0] k1_dp_state_o;
  logic [31:0]  k1_ks_word_o, k1_sb_word_o, k1_sb_word_i;
`ifdef AES_SBOX_SCHED_STATS_EN
  logic [15:0]  dp_cnt, ks_cnt, k1_dp_cnt, k1_ks_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;
  bit last_ks;
  int dp_grants, ks_grants;
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t[256];

  int           kind;
  logic [127:0] r_st;
  logic         r_mode;
  logic [31:0]  r_w;

  always #5 clk = ~clk;

  aes256_sbox_sched #(.KS_PRIORITY(KS_PRIO)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .dp_req_i(dp_req), .dp_mode_i(dp_mode), .dp_state_i(dp_state_in),
    .dp_ack_o(dp_ack), .dp_done_o(dp_done), .dp_state_o(dp_state_o),
    .ks_req_i(ks_req), .ks_word_i(ks_word),
    .ks_ack_o(ks_ack), .ks_done_o(ks_done), .ks_word_o(ks_word_o),
    .sb_word_o(sb_word_o), .sb_mode_o(sb_mode_o), .sb_word_i(sb_word_i),
`ifdef AES_SBOX_SCHED_STATS_EN
    .dp_grant_cnt_o(dp_cnt), .ks_grant_cnt_o(ks_cnt),
`endif
    .busy_o(busy)
  );

  aes256_sbox_sched #(.KS_PRIORITY(1)) u_dut_kp (
    .clk_i(clk), .rst_i(rst),
    .dp_req_i(dp_req), .dp_mode_i(dp_mode), .dp_state_i(dp_state_in),
    .dp_ack_o(k1_dp_ack), .dp_done_o(k1_dp_done), .dp_state_o(k1_dp_state_o),
    .ks_req_i(ks_req), .ks_word_i(ks_word),
    .ks_ack_o(k1_ks_ack), .ks_done_o(k1_ks_done), .ks_word_o(k1_ks_word_o),
    .sb_word_o(k1_sb_word_o), .sb_mode_o(k1_sb_mode_o), .sb_word_i(k1_sb_word_i),
`ifdef AES_SBOX_SCHED_STATS_EN
    .dp_grant_cnt_o(k1_dp_cnt), .ks_grant_cnt_o(k1_ks_cnt),
`endif
    .busy_o(k1_busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = inv ? isbox_t[w[8*i +: 8]] : sbox_t[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isbox_t[s[8*i +: 8]] : sbox_t[s[8*i +: 8]];
    return r;
  endfunction

  // Combinational slices seen by the two DUTs.
  always_comb sb_word_i    = sub_word(sb_word_o, sb_mode_o);
  always_comb k1_sb_word_i = sub_word(k1_sb_word_o, k1_sb_mode_o);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; dp_req = 1'b0; ks_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_ks = 1'b1; dp_grants = 0; ks_grants = 0;
  endtask

  // Waits for the done of an accepted operation; returns at the negedge of the done cycle.
  task automatic wait_done(input bit is_dp, input logic [127:0] st, input logic mode,
                           input logic [127:0] exp, input bit other_ack, input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, ".sb_word"}, sb_word_o, is_dp ? {96'b0, st[127:96]} : {96'b0, st[31:0]});
        chk({tag, ".sb_mode"}, sb_mode_o, is_dp ? mode : 1'b0);
        chk({tag, ".busy"}, busy, 1'b1);
      end
      if (is_dp ? dp_done : ks_done) begin
        n = i;
        break;
      end
    end
    chk({tag, ".latency"}, n, is_dp ? 5 : 2);
    chk({tag, ".result"}, is_dp ? dp_state_o : {96'b0, ks_word_o}, exp);
    if (other_ack) chk({tag, ".queued_ack"}, is_dp ? ks_ack : dp_ack, 1'b1);
  endtask

  task automatic op_single(input bit is_dp, input logic [127:0] st, input logic mode,
                           input logic [31:0] w, input logic [127:0] exp, input string tag);
    @(posedge clk); #1;
    if (is_dp) begin dp_req = 1'b1; dp_mode = mode; dp_state_in = st; end
    else begin ks_req = 1'b1; ks_word = w; end
    @(negedge clk);
    chk({tag, ".ack"}, is_dp ? dp_ack : ks_ack, 1'b1);
    @(posedge clk); #1;
    dp_req = 1'b0; ks_req = 1'b0;
    dp_state_in = {$urandom, $urandom, $urandom, $urandom}; ks_word = $urandom; dp_mode = ~mode;
    if (is_dp) dp_grants++; else ks_grants++;
    last_ks = !is_dp;
    wait_done(is_dp, is_dp ? st : {96'b0, w}, mode, exp, 1'b0, tag);
  endtask

  task automatic op_tie(input logic [127:0] st, input logic mode, input logic [31:0] w,
                        input bit check_kp, input string tag);
    bit first_dp;
    @(posedge clk); #1;
    dp_req = 1'b1; ks_req = 1'b1; dp_mode = mode; dp_state_in = st; ks_word = w;
    first_dp = (KS_PRIO != 0) ? 1'b0 : last_ks;
    @(negedge clk);
    chk({tag, ".dp_ack"}, dp_ack, first_dp);
    chk({tag, ".ks_ack"}, ks_ack, !first_dp);
    if (check_kp) begin
      chk({tag, ".kp_ks_ack"}, k1_ks_ack, 1'b1);
      chk({tag, ".kp_dp_ack"}, k1_dp_ack, 1'b0);
    end
    @(posedge clk); #1;
    if (first_dp) begin dp_req = 1'b0; dp_state_in = {$urandom, $urandom, $urandom, $urandom}; dp_grants++; end
    else begin ks_req = 1'b0; ks_word = $urandom; ks_grants++; end
    wait_done(first_dp, first_dp ? st : {96'b0, w}, mode,
              first_dp ? sub_state(st, mode) : {96'b0, sub_word(w, 1'b0)}, 1'b1, {tag, ".first"});
    @(posedge clk); #1;
    if (first_dp) begin ks_req = 1'b0; ks_grants++; end
    else begin dp_req = 1'b0; dp_grants++; end
    wait_done(!first_dp, !first_dp ? st : {96'b0, w}, mode,
              !first_dp ? sub_state(st, mode) : {96'b0, sub_word(w, 1'b0)}, 1'b0, {tag, ".second"});
    last_ks = first_dp;
  endtask

  initial begin
    int seen;
    rst = 1'b1; dp_req = 1'b0; ks_req = 1'b0; dp_mode = 1'b0;
    dp_state_in = '0; ks_word = '0;
    build_tables();
    do_reset();

    @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.acks", {dp_ack, ks_ack, dp_done, ks_done}, 4'b0);
    chk("rst.dp_state", dp_state_o, 128'd0);
    chk("rst.ks_word", ks_word_o, 32'd0);
    chk("rst.sb", {sb_mode_o, sb_word_o}, 33'd0);
    chk("rst.kp_outs", {k1_busy, k1_dp_done, k1_ks_done, k1_dp_state_o, k1_ks_word_o}, '0);

    op_single(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 32'd0,
              128'h638293C3_1BFC33F5_C4EEACEA_4BC12816, "dp_enc");
    op_single(1'b1, 128'h638293C3_1BFC33F5_C4EEACEA_4BC12816, 1'b1, 32'd0,
              128'h00112233_44556677_8899AABB_CCDDEEFF, "dp_dec");
    op_single(1'b0, 128'd0, 1'b0, 32'h00000000, 128'h63636363, "ks_zero");
    op_single(1'b0, 128'd0, 1'b0, 32'h53535353, 128'hEDEDEDED, "ks_53");

    do_reset();
    op_tie({$urandom, $urandom, $urandom, $urandom}, 1'b0, $urandom, 1'b1, "tie0");
    op_tie({$urandom, $urandom, $urandom, $urandom}, 1'b1, $urandom, 1'b0, "tie1");

    // Reset while word 2 of a DP operation is on the slice.
    @(posedge clk); #1;
    dp_req = 1'b1; dp_mode = 1'b0; dp_state_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("midrst.ack", dp_ack, 1'b1);
    @(posedge clk); #1 dp_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_ks = 1'b1; dp_grants = 0; ks_grants = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dp_done) seen++;
      if (i == 0) begin
        chk("midrst.dp_state", dp_state_o, 128'd0);
        chk("midrst.busy", busy, 1'b0);
      end
    end
    chk("midrst.no_done", seen, 0);
    op_single(1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 32'd0,
              128'h638293C3_1BFC33F5_C4EEACEA_4BC12816, "postrst");

    for (int r = 0; r < 10; r++) begin
      kind   = $urandom_range(2, 0);
      r_st   = {$urandom, $urandom, $urandom, $urandom};
      r_mode = 1'($urandom_range(1, 0));
      r_w    = $urandom;
      case (kind)
        0:       op_single(1'b1, r_st, r_mode, r_w, sub_state(r_st, r_mode), "rnd_dp");
        1:       op_single(1'b0, r_st, r_mode, r_w, {96'b0, sub_word(r_w, 1'b0)}, "rnd_ks");
        default: op_tie(r_st, r_mode, r_w, 1'b0, "rnd_tie");
      endcase
    end

`ifdef AES_SBOX_SCHED_STATS_EN
    @(negedge clk);
    chk("stats.dp", dp_cnt, dp_grants);
    chk("stats.ks", ks_cnt, ks_grants);
    do_reset();
    op_single(1'b1, 128'd0, 1'b0, 32'd0, sub_state(128'd0, 1'b0), "st_dp0");
    op_single(1'b1, 128'd1, 1'b0, 32'd0, sub_state(128'd1, 1'b0), "st_dp1");
    op_single(1'b0, 128'd0, 1'b0, 32'h01020304, {96'b0, sub_word(32'h01020304, 1'b0)}, "st_ks0");
    op_single(1'b1, 128'd2, 1'b1, 32'd0, sub_state(128'd2, 1'b1), "st_dp2");
    op_single(1'b0, 128'd0, 1'b0, 32'hA5A5A5A5, {96'b0, sub_word(32'hA5A5A5A5, 1'b0)}, "st_ks1");
    @(negedge clk);
    chk("stats.dp3", dp_cnt, 16'd3);
    chk("stats.ks2", ks_cnt, 16'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
